// File: rtl/ps2_lane_input.sv
// PS/2 set-2 receiver for the rhythm-game lanes: syncs and filters the raw lines, deframes bytes,
// tracks F0/E0 prefixes and drives held/press/rel for A,S,K,L,Enter. "release" is a reserved word, so that pulse port is rel.
module ps2_lane_input #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] held,
  output logic [4:0] press,
  output logic [4:0] rel,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt, strobe;
  logic [FW-1:0] fcnt;
  state_t        state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          brk, ext;
  logic [4:0]    key;

  // Filtered clock flips on the FILTER_LEN-th consecutive sample of the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      fcnt      <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      strobe    <= 1'b0;
      if (clk_sync[1] != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt   <= ~filt;
          fcnt   <= '0;
          strobe <= filt;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (strobe) begin
        to_cnt <= '0;
        case (state)
          IDLE: if (!data_sync[1]) begin
            state <= DATA;
            bcnt  <= '0;
          end
          DATA: begin
            shreg <= {data_sync[1], shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_sync[1];
            state <= STOP;
          end
          default: begin
            if (data_sync[1] && ^{shreg, par}) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Extended prefix leaves only keypad Enter mapped.
  always_comb begin
    key = '0;
    case (scan_code)
      8'h1C:   key = 5'b00001;
      8'h1B:   key = 5'b00010;
      8'h42:   key = 5'b00100;
      8'h4B:   key = 5'b01000;
      8'h5A:   key = 5'b10000;
      default: key = '0;
    endcase
    if (ext && scan_code != 8'h5A) key = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held  <= '0;
      press <= '0;
      rel   <= '0;
      brk   <= 1'b0;
      ext   <= 1'b0;
    end else begin
      press <= '0;
      rel   <= '0;
      if (frame_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (code_valid) begin
        if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!brk && (held & key) == '0) begin
            held  <= held | key;
            press <= key;
          end else if (brk && (held & key) != '0) begin
            held <= held & ~key;
            rel  <= key;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_lane_input.sv
// Directed bench: bit-banged PS/2 frames against a spec-level key model checked every cycle.
module tb_ps2_lane_input;
  localparam int FL = 8;
  localparam int TO = 2000;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  logic [4:0] held, press, rel;
  logic [7:0] scan_code;
  logic code_valid, frame_err;

  always #5 clk = ~clk;

  ps2_lane_input #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .held(held), .press(press), .rel(rel), .scan_code(scan_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  int checks = 0, passes = 0;
  logic [7:0] exp_q[$];
  int exp_err = 0, err_seen = 0, code_seen = 0;
  int press_cnt[5] = '{default: 0};
  int rel_cnt[5]   = '{default: 0};
  logic [4:0] m_held = '0, m_press = '0, m_rel = '0;
  bit m_brk = 0, m_ext = 0, pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    m_press = '0;
    m_rel   = '0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      case (b)
        8'h1C: idx = 0;
        8'h1B: idx = 1;
        8'h42: idx = 2;
        8'h4B: idx = 3;
        8'h5A: idx = 4;
        default: idx = -1;
      endcase
      if (m_ext && b != 8'h5A) idx = -1;
      if (idx >= 0) begin
        if (!m_brk && !m_held[idx]) begin
          m_held[idx] = 1'b1; m_press[idx] = 1'b1;
        end else if (m_brk && m_held[idx]) begin
          m_held[idx] = 1'b0; m_rel[idx] = 1'b1;
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_held = '0; m_brk = 0; m_ext = 0; pending = 0;
      exp_q.delete();
      exp_err = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (press[i]) press_cnt[i]++;
        if (rel[i]) rel_cnt[i]++;
      end
      if (pending) begin
        chk("press", press, m_press);
        chk("release", rel, m_rel);
        chk("held", held, m_held);
        pending = 0;
      end else begin
        chk("quiet", {press, rel, held}, {10'b0, m_held});
      end
      if (frame_err) begin
        err_seen++;
        chk("frame_err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
        m_brk = 0;
        m_ext = 0;
      end
      if (code_valid) begin
        code_seen++;
        chk("code_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("scan_code", scan_code, exp_q.pop_front());
        model_byte(scan_code);
        pending = 1;
      end
    end
  end

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    if (good) exp_q.push_back(b);
    else exp_err++;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good ? ~^b : ^b);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int e0, c0, t;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {held, press, rel, scan_code, code_valid, frame_err}, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    send(8'h1C, 1);
    chk("makeA_scan", scan_code, 8'h1C);
    chk("makeA_held", held, 5'b00001);
    chk("makeA_press_cnt", press_cnt[0], 1);

    send(8'hF0, 1); send(8'h1C, 1);
    chk("breakA_held", held, 5'b00000);
    chk("breakA_rel_cnt", rel_cnt[0], 1);

    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1); send(8'h42, 1);
    chk("typematic_pressA", press_cnt[0], 2);
    chk("typematic_pressK", press_cnt[2], 1);
    chk("typematic_held", held, 5'b00101);

    send(8'hE0, 1); send(8'h5A, 1);
    chk("ext_enter_held", held, 5'b10101);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h5A, 1);
    chk("ext_enter_rel", rel_cnt[4], 1);
    chk("ext_enter_held2", held, 5'b00101);
    send(8'hE0, 1); send(8'h1C, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h1C, 1);
    chk("ext_ignored_held", held, 5'b00101);

    e0 = err_seen; c0 = code_seen;
    send(8'h1B, 0);
    chk("parity_err", err_seen, e0 + 1);
    chk("parity_no_code", code_seen, c0);
    chk("parity_held", held, 5'b00101);
    send(8'h1B, 1);
    chk("after_parity_held", held, 5'b00111);

    e0 = err_seen;
    exp_err++;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    t = 0;
    while (err_seen == e0 && t < TO + 500) begin
      @(posedge clk);
      t++;
    end
    chk("timeout_err", err_seen, e0 + 1);
    send(8'h4B, 1);
    chk("after_timeout_held", held, 5'b01111);

    e0 = err_seen; c0 = code_seen;
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (TO + 100) @(posedge clk);
    chk("glitch_no_err", err_seen, e0);
    chk("glitch_no_code", code_seen, c0);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_held", held, 0);
    chk("midreset_outputs", {press, rel, scan_code, code_valid, frame_err}, 0);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    send(8'h5A, 1);
    chk("post_reset_held", held, 5'b10000);

    repeat (20) @(posedge clk);
    chk("no_leftover_codes", exp_q.size(), 0);
    chk("no_leftover_errs", exp_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ps2_lane_input.md
Name: ps2_lane_input

Overview:
Upstream input stage for the 4-lane rhythm game. It receives raw PS/2 keyboard clock and data, deframes scan-code set 2 bytes, and tracks make/break prefixes. It presents per-key held levels plus single-cycle press and release pulses for lanes A/S/K/L and Enter to game_control. Async PS/2 lines are synchronised and glitch-filtered internally.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before filtered ps2_clk changes level
TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 100 MHz)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
held  out  5  level per key: bit0 A, bit1 S, bit2 K, bit3 L, bit4 Enter; 1 = currently down
press  out  5  one-cycle pulse on key-down transition, same bit map
release  out  5  one-cycle pulse on key-up transition, same bit map
scan_code  out  8  last correctly received byte, including F0/E0
code_valid  out  1  one-cycle pulse when scan_code updates
frame_err  out  1  one-cycle pulse on parity/stop error or timeout

Behaviour:
- Reset: held, press, release, scan_code, code_valid, frame_err = 0. FSM in IDLE, bit counter 0, brk/ext flags 0, filtered ps2_clk = 1, timeout counter 0.
- Input conditioning: 2-FF sync on both lines. Filtered clk flips only after FILTER_LEN consecutive samples of the new level. A falling edge of filtered clk is the sample strobe; data is sampled from the synced line at that strobe.
- Frame FSM, advancing on each strobe:
  - IDLE: data 0 -> DATA with counter 0. Data 1 -> stay in IDLE; this is not an error.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop = 1 and the 8 data bits plus parity contain an odd number of ones -> frame good; else frame_err pulse. Either way -> IDLE.
- Good frame: scan_code loaded, code_valid pulses on the cycle after the stop strobe.
- Timeout: counter clears on every strobe and while in IDLE. If it reaches TIMEOUT_CYCLES outside IDLE -> IDLE, frame_err pulse, partial byte discarded.
- Any frame_err clears brk and ext.
- Decode on code_valid; held/press/release update on the following cycle:
  - F0 sets brk. E0 sets ext. Neither clears the other.
  - Other byte: map 1C->A, 1B->S, 42->K, 4B->L, 5A->Enter. If ext=1, only 5A maps (keypad Enter); all other extended codes are ignored.
  - Mapped, brk=0: if held bit is 0, set it and pulse press; if already 1 (typematic repeat), no pulse.
  - Mapped, brk=1: if held bit is 1, clear it and pulse release; else no pulse.
  - Every non-prefix byte clears brk and ext, mapped or not.
- Pulses are exactly one cycle. At most one key changes per byte, so simultaneous press/release within one cycle is impossible.
- Reset mid-frame: state returns immediately to reset values; the remainder of the frame is treated as garbage until a stop bit plus an idle-high start search resynchronises. No held bit survives reset.

Test Plan:
- Make A: frame 0x1C (parity 0) -> code_valid with scan_code=0x1C; one cycle later press=00001, held=00001; no frame_err.
- Break A: frames F0, 1C after make -> release=00001 one cycle, held=00000; press stays 0.
- Typematic: 1C sent 3 times, then 42 -> exactly one press[0] pulse, then press[2]; held=00101.
- Extended: E0 5A -> press[4], held[4]=1. E0 F0 5A -> release[4]. E0 1C -> no change to held.
- Errors: frame 0x1B with wrong parity -> frame_err pulse, no code_valid, held unchanged, and a following good 1B gives press[1]. Five bits then silence -> frame_err after TIMEOUT_CYCLES; the next good frame decodes correctly.
- Glitch and reset: a ps2_clk low pulse of FILTER_LEN-1 cycles produces no bit sampled. Asserting rst while held=01111 -> all outputs 0 immediately.
